hazard_sb: RTL and testbench

HAZARD_SB -- requirements
Module: hazard_sb

---
 rtl/hazard_sb_if.sv | 44 ++++
 rtl/hazard_sb.sv | 115 +++++++++++
 tb/tb_hazard_sb.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hazard_sb_if.sv
// Hazard scoreboard bundle: ID-stage operand/dest info, branch/memory status in,
// pipeline register enables, squash controls, forwarding selects and stall count out.
// master = pipeline control that drives ID info; slave = hazard_sb.
interface hazard_sb_if #(
   parameter int REG_AW = 5,
   parameter int CW     = 16
);
   // ID-stage instruction description
   logic              id_valid;
   logic [REG_AW-1:0] rs1_addr_ID;
   logic [REG_AW-1:0] rs2_addr_ID;
   logic              rs1_used;
   logic              rs2_used;
   logic [REG_AW-1:0] rd_addr_ID;
   logic              reg_write_ID;
   logic              is_load_ID;
   // pipeline status
   logic              br_taken_EX;
   logic              mem_busy;
   // pipeline controls
   logic              en_IF;
   logic              en_IFID;
   logic              en_IDEX;
   logic              en_EXMEM;
   logic              NOP_IFID;
   logic              NOP_IDEX;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic [CW-1:0]     stall_cnt;

   modport master (
      output id_valid, rs1_addr_ID, rs2_addr_ID, rs1_used, rs2_used,
             rd_addr_ID, reg_write_ID, is_load_ID, br_taken_EX, mem_busy,
      input  en_IF, en_IFID, en_IDEX, en_EXMEM, NOP_IFID, NOP_IDEX,
             fwd_a, fwd_b, stall_cnt
   );

   modport slave (
      input  id_valid, rs1_addr_ID, rs2_addr_ID, rs1_used, rs2_used,
             rd_addr_ID, reg_write_ID, is_load_ID, br_taken_EX, mem_busy,
      output en_IF, en_IFID, en_IDEX, en_EXMEM, NOP_IFID, NOP_IDEX,
             fwd_a, fwd_b, stall_cnt
   );
endinterface

// File: rtl/hazard_sb.sv
// Pipeline hazard scoreboard: tracks destination registers of the DEPTH stages after ID,
// and produces stall/flush/forwarding controls combinationally in the same cycle (0 latency).
// mem_busy freezes the whole pipeline (all enables low); load-use or RAW stalls hold IF/ID and bubble ID/EX.
// Ports: clk, rst (sync, active-high); sb = hazard_sb_if.slave carrying ID info in, controls out.
module hazard_sb #(
   parameter int REG_AW = 5,
   parameter int DEPTH  = 3,
   parameter int FWD_EN = 1,
   parameter int CW     = 16
) (
   input logic        clk,
   input logic        rst,
   hazard_sb_if.slave sb
);

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rd;
      logic              ld;
   } sb_entry_t;

   // ent[0] = EX, ent[1] = MEM, ...
   sb_entry_t     ent [DEPTH];
   logic [CW-1:0] cnt;

   logic [DEPTH-1:0] m1;
   logic [DEPTH-1:0] m2;
   logic             hit1_a;
   logic             hit1_b;
   logic             data_stall;
   logic             stall_inc;
   sb_entry_t        new_ent;

   // Source-to-entry matches; address 0 never matches so x0 can't stall or forward.
   always_comb begin
      m1 = '0;
      m2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         m1[i] = sb.rs1_used && (sb.rs1_addr_ID != '0) && ent[i].v && (ent[i].rd == sb.rs1_addr_ID);
         m2[i] = sb.rs2_used && (sb.rs2_addr_ID != '0) && ent[i].v && (ent[i].rd == sb.rs2_addr_ID);
      end
   end

   // MEM-stage hit only exists when the scoreboard is at least two deep.
   if (DEPTH > 1) begin : g_mem_hit
      assign hit1_a = m1[1];
      assign hit1_b = m2[1];
   end else begin : g_no_mem_hit
      assign hit1_a = 1'b0;
      assign hit1_b = 1'b0;
   end

   // With forwarding only a load in EX can't be bypassed; without it any in-flight writer blocks.
   if (FWD_EN != 0) begin : g_fwd_stall
      assign data_stall = (m1[0] | m2[0]) & ent[0].ld;
   end else begin : g_raw_stall
      assign data_stall = |(m1 | m2);
   end

   // A taken branch during mem_busy is deferred, so busy cycles always count as stalls.
   assign stall_inc = sb.mem_busy | (data_stall & ~sb.br_taken_EX);

   assign new_ent.v  = sb.id_valid & sb.reg_write_ID & (sb.rd_addr_ID != '0);
   assign new_ent.rd = sb.rd_addr_ID;
   assign new_ent.ld = sb.is_load_ID;

   always_comb begin
      sb.en_IF    = 1'b1;
      sb.en_IFID  = 1'b1;
      sb.en_IDEX  = 1'b1;
      sb.en_EXMEM = 1'b1;
      sb.NOP_IFID = 1'b0;
      sb.NOP_IDEX = 1'b0;
      sb.fwd_a    = 2'b00;
      sb.fwd_b    = 2'b00;
      if (!rst) begin
         // Youngest producer wins; entries at index 2+ are served by the write-first regfile.
         if (FWD_EN != 0) begin
            if (m1[0] && !ent[0].ld) sb.fwd_a = 2'b01;
            else if (hit1_a)         sb.fwd_a = 2'b10;
            if (m2[0] && !ent[0].ld) sb.fwd_b = 2'b01;
            else if (hit1_b)         sb.fwd_b = 2'b10;
         end
         if (sb.mem_busy) begin
            sb.en_IF    = 1'b0;
            sb.en_IFID  = 1'b0;
            sb.en_IDEX  = 1'b0;
            sb.en_EXMEM = 1'b0;
         end else if (sb.br_taken_EX) begin
            sb.NOP_IFID = 1'b1;
            sb.NOP_IDEX = 1'b1;
         end else if (data_stall) begin
            sb.en_IF    = 1'b0;
            sb.en_IFID  = 1'b0;
            sb.NOP_IDEX = 1'b1;
         end
      end
   end

   assign sb.stall_cnt = cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
         cnt <= '0;
      end else begin
         if (!sb.mem_busy) begin
            ent[0] <= (sb.br_taken_EX || data_stall) ? '0 : new_ent;
            for (int i = 1; i < DEPTH; i++) ent[i] <= ent[i-1];
         end
         if (stall_inc && (cnt != '1)) cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_hazard_sb.sv
module tb_hazard_sb;

   localparam logic [31:0] CTL_RUN   = 32'h3C;  // en all 1, NOP 0
   localparam logic [31:0] CTL_STALL = 32'h0D;  // en_IF/en_IFID 0, NOP_IDEX 1
   localparam logic [31:0] CTL_FLUSH = 32'h3F;  // en all 1, NOP both 1
   localparam logic [31:0] CTL_BUSY  = 32'h00;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       id_valid, rs1_used, rs2_used, reg_write, is_load, br, busy;
   logic [4:0] rs1, rs2, rd;

   int n_chk  = 0;
   int n_pass = 0;

   hazard_sb_if #(.REG_AW(5), .CW(16)) ifa ();
   hazard_sb_if #(.REG_AW(5), .CW(4))  ifb ();

   assign ifa.id_valid = id_valid;   assign ifb.id_valid = id_valid;
   assign ifa.rs1_addr_ID = rs1;     assign ifb.rs1_addr_ID = rs1;
   assign ifa.rs2_addr_ID = rs2;     assign ifb.rs2_addr_ID = rs2;
   assign ifa.rs1_used = rs1_used;   assign ifb.rs1_used = rs1_used;
   assign ifa.rs2_used = rs2_used;   assign ifb.rs2_used = rs2_used;
   assign ifa.rd_addr_ID = rd;       assign ifb.rd_addr_ID = rd;
   assign ifa.reg_write_ID = reg_write; assign ifb.reg_write_ID = reg_write;
   assign ifa.is_load_ID = is_load;  assign ifb.is_load_ID = is_load;
   assign ifa.br_taken_EX = br;      assign ifb.br_taken_EX = br;
   assign ifa.mem_busy = busy;       assign ifb.mem_busy = busy;

   hazard_sb #(.REG_AW(5), .DEPTH(3), .FWD_EN(1), .CW(16)) dut_a (.clk(clk), .rst(rst), .sb(ifa));
   hazard_sb #(.REG_AW(5), .DEPTH(3), .FWD_EN(0), .CW(4))  dut_b (.clk(clk), .rst(rst), .sb(ifb));

   function automatic logic [31:0] ctl_a();
      return {26'd0, ifa.en_IF, ifa.en_IFID, ifa.en_IDEX, ifa.en_EXMEM, ifa.NOP_IFID, ifa.NOP_IDEX};
   endfunction
   function automatic logic [31:0] ctl_b();
      return {26'd0, ifb.en_IF, ifb.en_IFID, ifb.en_IDEX, ifb.en_EXMEM, ifb.NOP_IFID, ifb.NOP_IDEX};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle();
      id_valid = 1'b0; rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
      rd = '0; reg_write = 1'b0; is_load = 1'b0; br = 1'b0; busy = 1'b0;
   endtask

   task automatic set_id(input logic [4:0] a1, input logic u1, input logic [4:0] a2,
                         input logic u2, input logic [4:0] d, input logic wr, input logic ld);
      id_valid = 1'b1; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
      rd = d; reg_write = wr; is_load = ld; br = 1'b0; busy = 1'b0;
   endtask

   initial begin
      // Reset with busy, branch and a would-be hazard all present: outputs forced
      rst = 1'b1;
      set_id(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
      br = 1'b1; busy = 1'b1;
      mid();
      chk("rst_ctl_a", ctl_a(), CTL_RUN);
      chk("rst_ctl_b", ctl_b(), CTL_RUN);
      chk("rst_fwd_a", 32'(ifa.fwd_a), 0);
      chk("rst_cnt_a", 32'(ifa.stall_cnt), 0);
      chk("rst_cnt_b", 32'(ifb.stall_cnt), 0);

      step(); rst = 1'b0; idle();
      mid(); chk("empty_ctl", ctl_a(), CTL_RUN);

      // lw x5 then add x6,x5,x7 -> one load-use stall then MEM forward
      step(); set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      mid(); chk("lw_ctl", ctl_a(), CTL_RUN);
      step(); set_id(5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
      mid(); chk("lu_stall", ctl_a(), CTL_STALL);
      chk("lu_cnt0", 32'(ifa.stall_cnt), 0);
      step();
      mid(); chk("lu_release", ctl_a(), CTL_RUN);
      chk("lu_fwd_a", 32'(ifa.fwd_a), 2);
      chk("lu_fwd_b", 32'(ifa.fwd_b), 0);
      chk("lu_cnt1", 32'(ifa.stall_cnt), 1);

      // add x3 ; sub x4,x3,x3 ; or x7,x3,x6 (x6 now in entry 2 -> regfile)
      step(); set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
      mid(); chk("add3_fwd_a", 32'(ifa.fwd_a), 0);
      step(); set_id(5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
      mid(); chk("b2b_ctl", ctl_a(), CTL_RUN);
      chk("b2b_fwd_a", 32'(ifa.fwd_a), 1);
      chk("b2b_fwd_b", 32'(ifa.fwd_b), 1);
      step(); set_id(5'd3, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
      mid(); chk("mem_fwd_a", 32'(ifa.fwd_a), 2);
      chk("rf_fwd_b", 32'(ifa.fwd_b), 0);

      // lw x8 ; use x8 with a taken branch -> flush wins, no stall counted
      step(); set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
      mid(); chk("lw8_ctl", ctl_a(), CTL_RUN);
      step(); set_id(5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0); br = 1'b1;
      mid(); chk("flush_ctl", ctl_a(), CTL_FLUSH);
      step(); idle();
      mid(); chk("flush_cnt", 32'(ifa.stall_cnt), 1);

      // busy 4 cycles with branch pending, flush on the 5th
      for (int k = 0; k < 4; k++) begin
         step(); idle(); busy = 1'b1; br = 1'b1;
         mid();
         chk("busy_ctl", ctl_a(), CTL_BUSY);
         chk("busy_cnt", 32'(ifa.stall_cnt), 32'(1 + k));
      end
      step(); idle(); br = 1'b1;
      mid(); chk("late_flush", ctl_a(), CTL_FLUSH);
      chk("late_cnt", 32'(ifa.stall_cnt), 5);

      // add x0 then read x0 (plus lw x5 as writer)
      step(); set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      mid(); chk("x0w_ctl", ctl_a(), CTL_RUN);
      step(); set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1);
      mid(); chk("x0_fwd_a", 32'(ifa.fwd_a), 0);
      chk("x0_ctl", ctl_a(), CTL_RUN);

      // load-use pending under busy, then reset abandons it
      step(); set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0); busy = 1'b1;
      mid(); chk("lu_busy_ctl", ctl_a(), CTL_BUSY);
      chk("lu_busy_cnt", 32'(ifa.stall_cnt), 5);
      step(); rst = 1'b1;
      mid(); chk("rst_busy_ctl", ctl_a(), CTL_RUN);
      step(); rst = 1'b0; set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
      mid(); chk("post_rst_ctl", ctl_a(), CTL_RUN);
      chk("post_rst_cnt", 32'(ifa.stall_cnt), 0);
      chk("post_rst_fwd", 32'(ifa.fwd_a), 0);

      // Stall-only instance: add x3 ; sub x4,x3,x3 -> 3 stall cycles
      step(); rst = 1'b1; idle();
      step(); rst = 1'b0; set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
      mid(); chk("b_add_ctl", ctl_b(), CTL_RUN);
      for (int k = 0; k < 3; k++) begin
         step(); set_id(5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
         mid();
         chk("b_raw_stall", ctl_b(), CTL_STALL);
         chk("b_fwd_a", 32'(ifb.fwd_a), 0);
         chk("a_no_stall", ctl_a(), CTL_RUN);
      end
      step(); set_id(5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
      mid(); chk("b_release", ctl_b(), CTL_RUN);
      chk("b_cnt3", 32'(ifb.stall_cnt), 3);
      chk("a_cnt0", 32'(ifa.stall_cnt), 0);

      // 20 busy cycles: CW=4 counter saturates at 15
      for (int k = 0; k < 20; k++) begin
         step(); idle(); busy = 1'b1;
         mid();
         if (k == 11) chk("b_cnt14", 32'(ifb.stall_cnt), 14);
      end
      step(); idle();
      mid(); chk("b_sat", 32'(ifb.stall_cnt), 15);
      chk("a_cnt20", 32'(ifa.stall_cnt), 20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
